hlen_extract: RTL and testbench

- Header-length extraction stage directly upstream of the HLEN register.
- Monitors the 64-bit packet word stream and locates the IPv4 version/IHL byte.
- Validates the header and produces the 64-bit HLEN value plus a one-cycle write strobe that drives the HLEN register's write enable.
- Pure sniffer: never stalls or modifies the stream. Keeps packet/error statistics.

---
 rtl/hlen_extract.sv | 248 ++++++++++++++++++++++++
 tb/tb_hlen_extract.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hlen_extract.sv
// ---------------------------------------------------------------------------
// hlen_extract
//
// Header-length extraction stage that sits directly upstream of the HLEN
// register. It passively watches a 64-bit packet word stream, finds the
// Ethernet ethertype and the IPv4 version/IHL byte in word 1, validates the
// header and produces the HLEN value together with a one-cycle write strobe
// for the HLEN register. The stream is never stalled or modified. Packet,
// error and non-IP statistics are kept in wrapping counters.
//
// Optional feature (compile-time macro HLEN_TOTLEN_EN):
//   When defined, a valid word 1 is followed by a capture of the IPv4 total
//   length from word 2 (in_data[63:48]); the strobe then writes
//   {32'd0, totlen, 10'd0, ihl, 2'b00}. A total length shorter than the
//   header, or a packet ending on word 1, is reported as hlen_err.
//   When undefined, hlen_value = {58'd0, ihl, 2'b00} and bits [31:6] are 0.
//
// Ports:
//   clk           in   1          system clock, rising edge
//   rst           in   1          synchronous reset, active-low
//   in_data       in   64         packet word, byte 0 = bits [63:56]
//   in_valid      in   1          qualifies in_data/in_sop/in_eop
//   in_sop        in   1          first word of packet
//   in_eop        in   1          last word of packet
//   hlen_value    out  64         HLEN value (HLEN register data)
//   hlen_write_en out  1          one-cycle HLEN register write strobe
//   hlen_err      out  1          one-cycle malformed/runt header strobe
//   pkt_cnt       out  CNT_WIDTH  IPv4 packets successfully parsed (wraps)
//   err_cnt       out  CNT_WIDTH  hlen_err events (wraps)
//   nonip_cnt     out  CNT_WIDTH  packets with non-IPv4 ethertype (wraps)
// ---------------------------------------------------------------------------
module hlen_extract #(
    parameter logic [15:0] ETHERTYPE_IPV4 = 16'h0800,
    parameter int          CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [63:0]          in_data,
    input  logic                 in_valid,
    input  logic                 in_sop,
    input  logic                 in_eop,
    output logic [63:0]          hlen_value,
    output logic                 hlen_write_en,
    output logic                 hlen_err,
    output logic [CNT_WIDTH-1:0] pkt_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic [CNT_WIDTH-1:0] nonip_cnt
);

    // S_W2 exists in the encoding in every build but is only reachable when
    // the total-length capture is compiled in.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_W1    = 2'd1,
        S_W2    = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // Counter index map for the statistics block.
    localparam int CNT_PKT   = 0;
    localparam int CNT_ERR   = 1;
    localparam int CNT_NONIP = 2;
    localparam int NUM_CNT   = 3;

    state_t state_reg;
    state_t state_next;

    logic [63:0] hlen_value_reg;
    logic [63:0] hlen_value_next;
    logic        hlen_write_en_reg;
    logic        hlen_write_en_next;
    logic        hlen_err_reg;
    logic        hlen_err_next;

    logic [NUM_CNT-1:0]  cnt_inc;
    logic                nonip_hit;
    logic [CNT_WIDTH-1:0] cnt_bus [NUM_CNT];

    // Word-1 header fields.
    logic [15:0] ethertype;
    logic [3:0]  ip_ver;
    logic [3:0]  ip_ihl;

    assign ethertype = in_data[31:16];
    assign ip_ver    = in_data[15:12];
    assign ip_ihl    = in_data[11:8];

`ifdef HLEN_TOTLEN_EN
    // IHL must survive from word 1 to word 2 for the length comparison.
    logic [3:0]  ihl_reg;
    logic [3:0]  ihl_next;
    logic [15:0] totlen;
    logic [15:0] hdr_bytes;

    assign totlen    = in_data[63:48];
    assign hdr_bytes = {10'd0, ihl_reg, 2'b00};

    logic unused_data_bits;
    assign unused_data_bits = ^{in_data[47:32], in_data[7:0]};
`else
    logic unused_data_bits;
    assign unused_data_bits = ^{in_data[63:32], in_data[7:0]};
`endif

    // -----------------------------------------------------------------------
    // Next-state / output decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_next         = state_reg;
        hlen_value_next    = hlen_value_reg;
        hlen_write_en_next = 1'b0;
        hlen_err_next      = 1'b0;
        nonip_hit          = 1'b0;
`ifdef HLEN_TOTLEN_EN
        ihl_next           = ihl_reg;
`endif

        if (in_valid) begin
            if (in_sop) begin
                // A sop always starts a new packet. If the header of the
                // previous packet was still being parsed it is a runt. A
                // single-word packet is a runt in its own right; both cases
                // collapse into one error strobe.
                if (state_reg == S_W1 || state_reg == S_W2) begin
                    hlen_err_next = 1'b1;
                end
                if (in_eop) begin
                    hlen_err_next = 1'b1;
                    state_next    = S_IDLE;
                end else begin
                    state_next    = S_W1;
                end
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        // Words outside a packet are ignored.
                        state_next = S_IDLE;
                    end

                    S_W1: begin
                        state_next = in_eop ? S_IDLE : S_DRAIN;
                        if (ethertype != ETHERTYPE_IPV4) begin
                            nonip_hit = 1'b1;
                        end else if (ip_ver != 4'd4 || ip_ihl < 4'd5) begin
                            hlen_err_next = 1'b1;
                        end else begin
`ifdef HLEN_TOTLEN_EN
                            if (in_eop) begin
                                // Total length lives in word 2, which never
                                // arrives.
                                hlen_err_next = 1'b1;
                            end else begin
                                ihl_next   = ip_ihl;
                                state_next = S_W2;
                            end
`else
                            hlen_write_en_next = 1'b1;
                            hlen_value_next    = {58'd0, ip_ihl, 2'b00};
`endif
                        end
                    end

`ifdef HLEN_TOTLEN_EN
                    S_W2: begin
                        state_next = in_eop ? S_IDLE : S_DRAIN;
                        if (totlen < hdr_bytes) begin
                            hlen_err_next = 1'b1;
                        end else begin
                            hlen_write_en_next = 1'b1;
                            hlen_value_next    = {32'd0, totlen, 10'd0, ihl_reg, 2'b00};
                        end
                    end
`endif

                    S_DRAIN: begin
                        if (in_eop) begin
                            state_next = S_IDLE;
                        end
                    end

                    default: begin
                        state_next = S_IDLE;
                    end
                endcase
            end
        end

        cnt_inc            = '0;
        cnt_inc[CNT_PKT]   = hlen_write_en_next;
        cnt_inc[CNT_ERR]   = hlen_err_next;
        cnt_inc[CNT_NONIP] = nonip_hit;
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg         <= S_IDLE;
            hlen_value_reg    <= 64'd0;
            hlen_write_en_reg <= 1'b0;
            hlen_err_reg      <= 1'b0;
        end else begin
            state_reg         <= state_next;
            hlen_value_reg    <= hlen_value_next;
            hlen_write_en_reg <= hlen_write_en_next;
            hlen_err_reg      <= hlen_err_next;
        end
    end

`ifdef HLEN_TOTLEN_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            ihl_reg <= 4'd0;
        end else begin
            ihl_reg <= ihl_next;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Statistics counters: identical wrapping incrementers, one per event.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : gen_cnt
            logic [CNT_WIDTH-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi]) begin
                    cnt_reg <= cnt_reg + CNT_WIDTH'(1);
                end
            end

            assign cnt_bus[gi] = cnt_reg;
        end
    endgenerate

    assign hlen_value    = hlen_value_reg;
    assign hlen_write_en = hlen_write_en_reg;
    assign hlen_err      = hlen_err_reg;
    assign pkt_cnt       = cnt_bus[CNT_PKT];
    assign err_cnt       = cnt_bus[CNT_ERR];
    assign nonip_cnt     = cnt_bus[CNT_NONIP];

endmodule

// File: tb/tb_hlen_extract.sv
// ---------------------------------------------------------------------------
// tb_hlen_extract
//
// Self-checking bench for hlen_extract. Packets are described by their
// header fields; a packet-level reference model decides what each packet
// should produce (write, error, non-IP, nothing) and the bench compares the
// strobes, hlen_value and the three counters after every packet.
// ---------------------------------------------------------------------------
module tb_hlen_extract;

    logic        clk;
    logic        rst;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_sop;
    logic        in_eop;
    logic [63:0] hlen_value;
    logic        hlen_write_en;
    logic        hlen_err;
    logic [15:0] pkt_cnt;
    logic [15:0] err_cnt;
    logic [15:0] nonip_cnt;

    hlen_extract #(
        .ETHERTYPE_IPV4(16'h0800),
        .CNT_WIDTH     (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_sop       (in_sop),
        .in_eop       (in_eop),
        .hlen_value   (hlen_value),
        .hlen_write_en(hlen_write_en),
        .hlen_err     (hlen_err),
        .pkt_cnt      (pkt_cnt),
        .err_cnt      (err_cnt),
        .nonip_cnt    (nonip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [63:0] exp_value;
    logic [15:0] exp_pkt;
    logic [15:0] exp_err;
    logic [15:0] exp_nonip;

    // Strobe pulse counters (sampled on the falling edge)
    int we_pulses  = 0;
    int err_pulses = 0;

    always @(negedge clk) begin
        if (hlen_write_en === 1'b1) we_pulses++;
        if (hlen_err === 1'b1) err_pulses++;
        if (hlen_write_en === 1'b1 || hlen_err === 1'b1) begin
            n_checks++;
            if (hlen_write_en === 1'b1 && hlen_err === 1'b1)
                $display("FAIL strobe_exclusive: write_en=%b err=%b required not both 1",
                         hlen_write_en, hlen_err);
            else
                n_pass++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus primitives
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in_sop   = 1'($urandom);
            in_eop   = 1'($urandom);
            in_data  = {$urandom, $urandom};
            @(posedge clk);
            #1;
        end
        in_sop = 1'b0;
        in_eop = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] d, input logic s, input logic e);
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    function automatic logic [63:0] make_w1(input logic [15:0] et, input logic [3:0] ver,
                                             input logic [3:0] ihl);
        logic [63:0] w;
        w        = {$urandom, $urandom};
        w[31:16] = et;
        w[15:12] = ver;
        w[11:8]  = ihl;
        return w;
    endfunction

    function automatic logic [63:0] make_w2(input logic [15:0] totlen);
        logic [63:0] w;
        w        = {$urandom, $urandom};
        w[63:48] = totlen;
        return w;
    endfunction

    // ------------------------------------------------------------------
    // One packet through the DUT, checked against the packet-level model.
    // pre_err: error strobes expected in addition to the packet's own
    // outcome (a previous header aborted by this packet's sop).
    // ------------------------------------------------------------------
    task automatic send_packet(input string name, input int nw, input logic [15:0] et,
                               input logic [3:0] ver, input logic [3:0] ihl,
                               input logic [15:0] totlen, input int gap_max,
                               input int pre_err);
        logic        m_ok, m_err, m_nonip;
        logic [63:0] m_value;
        int          ev_word;
        int          we0, er0;
        logic [63:0] w;
        int          hdr;

        hdr     = int'(ihl) * 4;
        m_ok    = 1'b0;
        m_err   = 1'b0;
        m_nonip = 1'b0;
        m_value = exp_value;
        ev_word = 1;
        if (nw == 1) begin
            m_err   = 1'b1;
            ev_word = 0;
        end else if (et != 16'h0800) begin
            m_nonip = 1'b1;
        end else if (ver != 4'd4 || ihl < 4'd5) begin
            m_err = 1'b1;
        end else begin
`ifdef HLEN_TOTLEN_EN
            if (nw == 2) begin
                m_err = 1'b1;
            end else begin
                ev_word = 2;
                if (int'(totlen) < hdr) begin
                    m_err = 1'b1;
                end else begin
                    m_ok    = 1'b1;
                    m_value = {32'd0, totlen, 10'd0, ihl, 2'b00};
                end
            end
`else
            m_ok    = 1'b1;
            m_value = 64'(hdr);
`endif
        end

        we0 = we_pulses;
        er0 = err_pulses;

        for (int i = 0; i < nw; i++) begin
            if (gap_max > 0) idle($urandom_range(gap_max, 0));
            if (i == 1) w = make_w1(et, ver, ihl);
            else if (i == 2) w = make_w2(totlen);
            else w = {$urandom, $urandom};
            send_word(w, i == 0, i == nw - 1);
            if (i == ev_word) begin
                n_checks++;
                if (hlen_write_en !== m_ok)
                    $display("FAIL %s_we_latency: got %b expected %b", name, hlen_write_en, m_ok);
                else n_pass++;
                n_checks++;
                if (hlen_err !== m_err)
                    $display("FAIL %s_err_latency: got %b expected %b", name, hlen_err, m_err);
                else n_pass++;
            end
        end

        exp_value = m_value;
        if (m_ok) exp_pkt++;
        if (m_nonip) exp_nonip++;
        exp_err = exp_err + 16'(pre_err) + 16'(m_err);

        idle(2);

        n_checks++;
        if (we_pulses - we0 !== int'(m_ok))
            $display("FAIL %s_we_pulses: got %0d expected %0d", name, we_pulses - we0, m_ok);
        else n_pass++;
        n_checks++;
        if (err_pulses - er0 !== pre_err + int'(m_err))
            $display("FAIL %s_err_pulses: got %0d expected %0d", name, err_pulses - er0,
                     pre_err + int'(m_err));
        else n_pass++;
        n_checks++;
        if (hlen_value !== exp_value)
            $display("FAIL %s_value: got %h expected %h", name, hlen_value, exp_value);
        else n_pass++;
        n_checks++;
        if (pkt_cnt !== exp_pkt)
            $display("FAIL %s_pkt_cnt: got %0d expected %0d", name, pkt_cnt, exp_pkt);
        else n_pass++;
        n_checks++;
        if (err_cnt !== exp_err)
            $display("FAIL %s_err_cnt: got %0d expected %0d", name, err_cnt, exp_err);
        else n_pass++;
        n_checks++;
        if (nonip_cnt !== exp_nonip)
            $display("FAIL %s_nonip_cnt: got %0d expected %0d", name, nonip_cnt, exp_nonip);
        else n_pass++;

        $display("pkt %-10s nw=%0d et=%h ver=%0d ihl=%0d totlen=%0d -> value=%h pkt=%0d err=%0d nonip=%0d",
                 name, nw, et, ver, ihl, totlen, hlen_value, pkt_cnt, err_cnt, nonip_cnt);
    endtask

    task automatic model_reset();
        exp_value = 64'd0;
        exp_pkt   = 16'd0;
        exp_err   = 16'd0;
        exp_nonip = 16'd0;
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if (hlen_value !== 64'd0) $display("FAIL %s_value: got %h expected 0", name, hlen_value);
        else n_pass++;
        n_checks++;
        if (hlen_write_en !== 1'b0) $display("FAIL %s_we: got %b expected 0", name, hlen_write_en);
        else n_pass++;
        n_checks++;
        if (hlen_err !== 1'b0) $display("FAIL %s_err: got %b expected 0", name, hlen_err);
        else n_pass++;
        n_checks++;
        if (pkt_cnt !== 16'd0) $display("FAIL %s_pkt_cnt: got %0d expected 0", name, pkt_cnt);
        else n_pass++;
        n_checks++;
        if (err_cnt !== 16'd0) $display("FAIL %s_err_cnt: got %0d expected 0", name, err_cnt);
        else n_pass++;
        n_checks++;
        if (nonip_cnt !== 16'd0) $display("FAIL %s_nonip_cnt: got %0d expected 0", name, nonip_cnt);
        else n_pass++;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom);
            in_sop   = 1'($urandom);
            in_eop   = 1'($urandom);
            in_data  = {$urandom, $urandom};
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        model_reset();
        check_all_zero("reset");
        $display("reset  value=%h pkt=%0d err=%0d nonip=%0d", hlen_value, pkt_cnt, err_cnt, nonip_cnt);
        rst = 1'b1;
        idle(1);
    endtask

    task automatic test_basic();
        send_packet("basic", 4, 16'h0800, 4'd4, 4'd5, 16'd40, 0, 0);
    endtask

    task automatic test_gaps();
        send_packet("gaps", 4, 16'h0800, 4'd4, 4'hF, 16'd100, 3, 0);
    endtask

    task automatic test_arp();
        send_packet("arp", 4, 16'h0806, 4'd4, 4'd5, 16'd40, 1, 0);
    endtask

    task automatic test_bad_ihl();
        send_packet("bad_ihl", 4, 16'h0800, 4'd4, 4'd4, 16'd40, 0, 0);
        send_packet("bad_ver", 3, 16'h0800, 4'd6, 4'd5, 16'd40, 0, 0);
    endtask

    task automatic test_runt();
        send_packet("runt", 1, 16'h0800, 4'd4, 4'd5, 16'd40, 0, 0);
    endtask

    task automatic test_abort();
        // Reset while the header is pending.
        send_word({$urandom, $urandom}, 1'b1, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        check_all_zero("rst_in_w1");
        $display("abort  reset during header, value=%h pkt=%0d", hlen_value, pkt_cnt);
        send_packet("after_rst", 4, 16'h0800, 4'd4, 4'd5, 16'd40, 1, 0);

        // Packet cut short after its header: the new sop restarts parsing.
        send_word({$urandom, $urandom}, 1'b1, 1'b0);
        send_word(make_w1(16'h0800, 4'd4, 4'd6), 1'b0, 1'b0);
        send_word(make_w2(16'd100), 1'b0, 1'b0);
        idle(1);
`ifdef HLEN_TOTLEN_EN
        exp_value = {32'd0, 16'd100, 10'd0, 4'd6, 2'b00};
`else
        exp_value = 64'd24;
`endif
        exp_pkt++;
        n_checks++;
        if (hlen_value !== exp_value)
            $display("FAIL drain_abort_value: got %h expected %h", hlen_value, exp_value);
        else n_pass++;
        $display("abort  truncated packet in drain, value=%h", hlen_value);
        send_packet("after_drn", 4, 16'h0800, 4'd4, 4'd7, 16'd200, 0, 0);

        // sop while waiting for word 1: runt error at the new sop.
        send_word({$urandom, $urandom}, 1'b1, 1'b0);
        send_packet("after_w1", 4, 16'h0800, 4'd4, 4'd8, 16'd300, 0, 1);
    endtask

`ifdef HLEN_TOTLEN_EN
    task automatic test_totlen();
        send_packet("totlen", 4, 16'h0800, 4'd4, 4'd5, 16'd84, 0, 0);
        n_checks++;
        if (hlen_value !== 64'h0000_0000_0054_0014)
            $display("FAIL totlen_value: got %h expected %h", hlen_value, 64'h0000_0000_0054_0014);
        else n_pass++;
        send_packet("short_tl", 4, 16'h0800, 4'd4, 4'd6, 16'd20, 0, 0);
        send_packet("eop_w1", 2, 16'h0800, 4'd4, 4'd5, 16'd84, 0, 0);
    endtask
`endif

    task automatic test_random();
        for (int p = 0; p < 40; p++) begin
            logic [15:0] et;
            logic [3:0]  ver;
            logic [3:0]  ihl;
            logic [15:0] tl;
            int          nw;
            et  = ($urandom_range(3, 0) != 0) ? 16'h0800 : 16'($urandom);
            ver = ($urandom_range(4, 0) != 0) ? 4'd4 : 4'($urandom);
            ihl = 4'($urandom);
            tl  = ($urandom_range(1, 0) != 0) ? 16'($urandom_range(1500, 0)) : 16'($urandom);
            nw  = $urandom_range(6, 1);
            send_packet($sformatf("rnd%0d", p), nw, et, ver, ihl, tl, $urandom_range(2, 0), 0);
        end
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_data  = 64'd0;
        model_reset();
        #1;

        test_reset();
        test_basic();
        test_gaps();
        test_arp();
        test_bad_ihl();
        test_runt();
        test_abort();
`ifdef HLEN_TOTLEN_EN
        test_totlen();
`endif
        test_random();

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
